// File: rtl/hazard_detection_unit.sv
// Hazard detection unit for the 5-stage, 16-register core.
// Stalls PC and IF/ID and injects ID/EX bubbles for load-use and ID-resolved
// branch dependencies, flushes IF/ID on taken branches, freezes the pipeline
// during memory misses (deferring branch flushes across the freeze), and keeps
// saturating stall and bubble counters.
module hazard_detection_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       IFID_Rs,
    input  logic [3:0]       IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             IFID_Branch,
    input  logic             branch_taken,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [3:0]       IDEX_Rd,
    input  logic             EXMem_MemRead,
    input  logic [3:0]       EXMem_Rd,
    input  logic             mem_stall,
    input  logic             cnt_clr,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IDEX_bubble,
    output logic             IFID_flush,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count
);

    typedef enum logic {
        StRun    = 1'b0,
        StFreeze = 1'b1
    } state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic       r_flush_pend;
    logic       w_flush_pend_next;

    logic       w_idex_rd_nz;
    logic       w_exmem_rd_nz;
    logic       w_load_use;
    logic       w_br_dep_ex;
    logic       w_br_dep_mem;
    logic       w_br_dep;
    logic       w_br_go;

    logic       w_pc_write;
    logic       w_ifid_write;
    logic       w_bubble;
    logic       w_flush;
    logic       w_freeze;

    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_bubble_count;

    // Register 0 is hardwired to zero, so it never carries a dependency.
    assign w_idex_rd_nz  = (IDEX_Rd != 4'd0);
    assign w_exmem_rd_nz = (EXMem_Rd != 4'd0);

    // Load in EX feeding a source of the instruction in ID: data arrives too late to forward.
    assign w_load_use = IDEX_MemRead & w_idex_rd_nz &
                        ((IDEX_Rd == IFID_Rs) | (IFID_UsesRt & (IDEX_Rd == IFID_Rt)));

    // Branches compare Rs in ID, so any producer still in EX, or a load still in MEM, blocks them.
    assign w_br_dep_ex  = IDEX_RegWrite & w_idex_rd_nz & (IDEX_Rd == IFID_Rs);
    assign w_br_dep_mem = EXMem_MemRead & w_exmem_rd_nz & (EXMem_Rd == IFID_Rs);
    assign w_br_dep     = IFID_Branch & (w_br_dep_ex | w_br_dep_mem);

    // branch_taken is only trustworthy once the branch operand is resolved.
    assign w_br_go = branch_taken & IFID_Branch & ~w_br_dep;

    // Next-state and control outputs; priority is freeze, then flush, then stall.
    always_comb begin
        w_pc_write        = 1'b1;
        w_ifid_write      = 1'b1;
        w_bubble          = 1'b0;
        w_flush           = 1'b0;
        w_freeze          = 1'b0;
        w_state_next      = r_state;
        w_flush_pend_next = r_flush_pend;

        if (mem_stall) begin
            w_freeze     = 1'b1;
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_state_next = StFreeze;
            // Entering a freeze captures a fresh branch decision; inside one we accumulate.
            if (r_state == StRun) begin
                w_flush_pend_next = w_br_go;
            end else begin
                w_flush_pend_next = r_flush_pend | w_br_go;
            end
        end else begin
            // Leaving a freeze takes the RUN rules in the same cycle, so a deferred flush fires now.
            w_state_next = StRun;
            if (w_br_go || r_flush_pend) begin
                w_flush           = 1'b1;
                w_flush_pend_next = 1'b0;
            end else if (w_load_use || w_br_dep) begin
                w_pc_write   = 1'b0;
                w_ifid_write = 1'b0;
                w_bubble     = 1'b1;
            end
        end

        // Reset overrides the controls combinationally so it takes effect without an edge.
        if (rst) begin
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_bubble     = 1'b0;
            w_flush      = 1'b0;
            w_freeze     = 1'b0;
        end
    end

    assign PC_write    = w_pc_write;
    assign IFID_write  = w_ifid_write;
    assign IDEX_bubble = w_bubble;
    assign IFID_flush  = w_flush;
    assign freeze      = w_freeze;

    // State register and deferred-flush flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StRun;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_flush_pend <= w_flush_pend_next;
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_bubble_count <= '0;
        end else if (cnt_clr) begin
            r_stall_cycles <= '0;
            r_bubble_count <= '0;
        end else begin
            if (!w_pc_write && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_bubble && (r_bubble_count != '1)) begin
                r_bubble_count <= r_bubble_count + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit (CNT_W=4 to reach saturation quickly).
module tb_hazard_detection_unit;

    localparam int unsigned CNT_W = 4;

    // Control output packing: {PC_write, IFID_write, IDEX_bubble, IFID_flush, freeze}
    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00100;
    localparam logic [4:0] O_FLUSH = 5'b11010;
    localparam logic [4:0] O_FRZ   = 5'b00001;

    typedef struct {
        logic [3:0] rs;
        logic [3:0] rt;
        logic       ur;
        logic       br;
        logic       tk;
        logic       imr;
        logic       irw;
        logic [3:0] ird;
        logic       emr;
        logic [3:0] erd;
        logic       ms;
    } in_t;

    typedef struct {
        in_t        in;
        logic [4:0] exp;
        string      name;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [3:0]       IFID_Rs;
    logic [3:0]       IFID_Rt;
    logic             IFID_UsesRt;
    logic             IFID_Branch;
    logic             branch_taken;
    logic             IDEX_MemRead;
    logic             IDEX_RegWrite;
    logic [3:0]       IDEX_Rd;
    logic             EXMem_MemRead;
    logic [3:0]       EXMem_Rd;
    logic             mem_stall;
    logic             cnt_clr;
    logic             PC_write;
    logic             IFID_write;
    logic             IDEX_bubble;
    logic             IFID_flush;
    logic             freeze;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] bubble_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] exp_q[$];
    string      name_q[$];
    vec_t       tbl[$];

    hazard_detection_unit #(
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .IFID_Rs      (IFID_Rs),
        .IFID_Rt      (IFID_Rt),
        .IFID_UsesRt  (IFID_UsesRt),
        .IFID_Branch  (IFID_Branch),
        .branch_taken (branch_taken),
        .IDEX_MemRead (IDEX_MemRead),
        .IDEX_RegWrite(IDEX_RegWrite),
        .IDEX_Rd      (IDEX_Rd),
        .EXMem_MemRead(EXMem_MemRead),
        .EXMem_Rd     (EXMem_Rd),
        .mem_stall    (mem_stall),
        .cnt_clr      (cnt_clr),
        .PC_write     (PC_write),
        .IFID_write   (IFID_write),
        .IDEX_bubble  (IDEX_bubble),
        .IFID_flush   (IFID_flush),
        .freeze       (freeze),
        .stall_cycles (stall_cycles),
        .bubble_count (bubble_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    function automatic in_t mk(input logic [3:0] rs, input logic [3:0] rt, input logic ur,
                               input logic br, input logic tk, input logic imr,
                               input logic irw, input logic [3:0] ird, input logic emr,
                               input logic [3:0] erd, input logic ms);
        in_t v;
        v.rs = rs; v.rt = rt; v.ur = ur; v.br = br; v.tk = tk; v.imr = imr;
        v.irw = irw; v.ird = ird; v.emr = emr; v.erd = erd; v.ms = ms;
        return v;
    endfunction

    function automatic in_t idle();
        return mk(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 4'd10, 1'b0);
    endfunction

    task automatic drive(input in_t v);
        IFID_Rs       = v.rs;
        IFID_Rt       = v.rt;
        IFID_UsesRt   = v.ur;
        IFID_Branch   = v.br;
        branch_taken  = v.tk;
        IDEX_MemRead  = v.imr;
        IDEX_RegWrite = v.irw;
        IDEX_Rd       = v.ird;
        EXMem_MemRead = v.emr;
        EXMem_Rd      = v.erd;
        mem_stall     = v.ms;
    endtask

    task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    function automatic logic [4:0] ctl();
        return {PC_write, IFID_write, IDEX_bubble, IFID_flush, freeze};
    endfunction

    // One cycle: drive, record expectation, compare at negedge, advance past the posedge.
    task automatic step(input in_t v, input logic [4:0] exp, input string nm);
        logic [4:0] e;
        string      n;
        drive(v);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk);
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check_val(n, {27'd0, ctl()}, {27'd0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        drive(idle());
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check_val("clr_stall", {28'd0, stall_cycles}, 32'd0);
    endtask

    initial begin
        in_t v;

        // Reset state
        rst     = 1'b1;
        cnt_clr = 1'b0;
        drive(idle());
        #1;
        check_val("reset_ctl", {27'd0, ctl()}, {27'd0, O_RUN});
        check_val("reset_stall", {28'd0, stall_cycles}, 32'd0);
        check_val("reset_bubble", {28'd0, bubble_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single-cycle decode table, all applied from RUN with nothing pending
        tbl.push_back('{mk(4'd1, 4'd2, 0, 0, 0, 0, 0, 4'd9, 0, 4'd10, 0), O_RUN, "idle"});
        tbl.push_back('{mk(4'd3, 4'd2, 0, 0, 0, 1, 1, 4'd3, 0, 4'd0, 0), O_STALL, "lu_rs"});
        tbl.push_back('{mk(4'd1, 4'd5, 0, 0, 0, 1, 1, 4'd5, 0, 4'd0, 0), O_RUN, "lu_rt_unused"});
        tbl.push_back('{mk(4'd1, 4'd5, 1, 0, 0, 1, 1, 4'd5, 0, 4'd0, 0), O_STALL, "lu_rt_used"});
        tbl.push_back('{mk(4'd0, 4'd0, 1, 0, 0, 1, 1, 4'd0, 0, 4'd0, 0), O_RUN, "lu_r0"});
        tbl.push_back('{mk(4'd3, 4'd2, 1, 0, 0, 1, 1, 4'd4, 0, 4'd0, 0), O_RUN, "lu_other"});
        tbl.push_back('{mk(4'd6, 4'd2, 0, 1, 1, 0, 1, 4'd6, 0, 4'd0, 0), O_STALL, "br_dep_alu"});
        tbl.push_back('{mk(4'd7, 4'd2, 0, 1, 1, 0, 0, 4'd9, 1, 4'd7, 0), O_STALL, "br_dep_mem"});
        tbl.push_back('{mk(4'd2, 4'd3, 0, 1, 1, 0, 1, 4'd9, 1, 4'd8, 0), O_FLUSH, "br_taken"});
        tbl.push_back('{mk(4'd2, 4'd3, 0, 1, 0, 0, 0, 4'd9, 0, 4'd8, 0), O_RUN, "br_not_taken"});
        tbl.push_back('{mk(4'd2, 4'd3, 0, 0, 1, 0, 0, 4'd9, 0, 4'd8, 0), O_RUN, "taken_no_br"});
        tbl.push_back('{mk(4'd0, 4'd3, 0, 1, 1, 0, 1, 4'd0, 1, 4'd0, 0), O_FLUSH, "br_r0"});
        tbl.push_back('{mk(4'd4, 4'd3, 0, 0, 0, 0, 1, 4'd4, 0, 4'd8, 0), O_RUN, "alu_fwd"});
        tbl.push_back('{mk(4'd4, 4'd3, 0, 0, 0, 0, 0, 4'd8, 1, 4'd4, 0), O_RUN, "mem_load_fwd"});
        tbl.push_back('{mk(4'd3, 4'd2, 0, 1, 1, 1, 0, 4'd3, 0, 4'd0, 0), O_FLUSH, "flush_over_lu"});
        tbl.push_back('{mk(4'd1, 4'd2, 0, 0, 0, 0, 0, 4'd9, 0, 4'd10, 0), O_RUN, "idle_end"});
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].in, tbl[i].exp, tbl[i].name);
        end
        check_val("tbl_stall", {28'd0, stall_cycles}, 32'd4);
        check_val("tbl_bubble", {28'd0, bubble_count}, 32'd4);

        // Load-use costs exactly one bubble
        clr();
        step(mk(4'd3, 4'd2, 0, 0, 0, 1, 1, 4'd3, 0, 4'd0, 0), O_STALL, "lu_seq0");
        step(idle(), O_RUN, "lu_seq1");
        check_val("lu_bubble", {28'd0, bubble_count}, 32'd1);
        check_val("lu_stall", {28'd0, stall_cycles}, 32'd1);

        // Branch behind a load: two bubbles, taken ignored, then one flush
        clr();
        step(mk(4'd7, 4'd2, 0, 1, 1, 1, 1, 4'd7, 0, 4'd0, 0), O_STALL, "brld_ex");
        step(mk(4'd7, 4'd2, 0, 1, 1, 0, 0, 4'd0, 1, 4'd7, 0), O_STALL, "brld_mem");
        step(mk(4'd7, 4'd2, 0, 1, 1, 0, 0, 4'd0, 0, 4'd0, 0), O_FLUSH, "brld_go");
        step(idle(), O_RUN, "brld_after");
        check_val("brld_bubble", {28'd0, bubble_count}, 32'd2);

        // Freeze with a pending flush: fires only after mem_stall falls
        clr();
        for (int i = 0; i < 4; i++) begin
            step(mk(4'd2, 4'd3, 0, 1, 1, 0, 0, 4'd9, 0, 4'd8, 1), O_FRZ, "frz_br");
        end
        step(idle(), O_FLUSH, "frz_pend_flush");
        step(idle(), O_RUN, "frz_after");
        check_val("frz_stall", {28'd0, stall_cycles}, 32'd4);
        check_val("frz_bubble", {28'd0, bubble_count}, 32'd0);

        // Hazard present during a freeze is re-evaluated after exit
        clr();
        v = mk(4'd3, 4'd2, 0, 0, 0, 1, 1, 4'd3, 0, 4'd0, 1);
        step(v, O_FRZ, "frz_lu0");
        step(v, O_FRZ, "frz_lu1");
        v.ms = 1'b0;
        step(v, O_STALL, "frz_lu_exit");
        step(idle(), O_RUN, "frz_lu_after");
        check_val("frz_lu_stall", {28'd0, stall_cycles}, 32'd3);
        check_val("frz_lu_bubble", {28'd0, bubble_count}, 32'd1);

        // Async reset mid-freeze drops freeze and pending flush
        clr();
        v = mk(4'd2, 4'd3, 0, 1, 1, 0, 0, 4'd9, 0, 4'd8, 1);
        step(v, O_FRZ, "rstf_c1");
        drive(v);
        #2;
        rst = 1'b1;
        #1;
        check_val("rstf_ctl", {27'd0, ctl()}, {27'd0, O_RUN});
        check_val("rstf_stall", {28'd0, stall_cycles}, 32'd0);
        @(posedge clk);
        #1;
        drive(idle());
        rst = 1'b0;
        step(idle(), O_RUN, "rstf_no_flush");

        // Saturation at 15 and clear-over-increment
        clr();
        v = mk(4'd3, 4'd2, 0, 0, 0, 1, 1, 4'd3, 0, 4'd0, 0);
        for (int i = 0; i < 20; i++) begin
            step(v, O_STALL, "sat_stall");
        end
        check_val("sat_stall_cnt", {28'd0, stall_cycles}, 32'd15);
        check_val("sat_bubble_cnt", {28'd0, bubble_count}, 32'd15);
        drive(v);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check_val("clr_pri_stall", {28'd0, stall_cycles}, 32'd0);
        check_val("clr_pri_bubble", {28'd0, bubble_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Pipeline hazard controller for the 5-stage, 16-register (4-bit ID) core. It sits in ID, opposite the EX/MEM forwarding logic: where forwarding resolves dependencies by steering data, this block resolves the ones forwarding cannot. It stalls PC and IF/ID and injects ID/EX bubbles for load-use and ID-resolved branch dependencies. It flushes IF/ID on taken branches and freezes the whole pipeline while the memory system reports a miss. A small state machine tracks freeze episodes and defers branch flushes across them, and saturating counters expose stall statistics.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- IFID_Rs  input  4  first source register of the instruction in ID.
- IFID_Rt  input  4  second source register of the instruction in ID.
- IFID_UsesRt  input  1  instruction in ID reads Rt.
- IFID_Branch  input  1  instruction in ID is a register-based branch (reads Rs in ID).
- branch_taken  input  1  ID branch resolution says taken; valid only when no branch dependency exists.
- IDEX_MemRead  input  1  instruction in EX is a load.
- IDEX_RegWrite  input  1  instruction in EX writes a register.
- IDEX_Rd  input  4  destination register of the instruction in EX.
- EXMem_MemRead  input  1  instruction in MEM is a load.
- EXMem_Rd  input  4  destination register of the instruction in MEM.
- mem_stall  input  1  I- or D-memory miss in progress; level, held until data is ready.
- cnt_clr  input  1  synchronous clear of both counters.
- PC_write  output  1  PC register enable.
- IFID_write  output  1  IF/ID register enable.
- IDEX_bubble  output  1  load a NOP into ID/EX (zero its control bits).
- IFID_flush  output  1  zero IF/ID on the next edge.
- freeze  output  1  hold every pipeline register (PC through MEM/WB).
- stall_cycles  output  CNT_W  cycles with PC_write=0.
- bubble_count  output  CNT_W  bubbles injected.

## Operation
- load_use = IDEX_MemRead & IDEX_Rd≠0 & (IDEX_Rd==IFID_Rs | (IFID_UsesRt & IDEX_Rd==IFID_Rt)).
- br_dep = IFID_Branch & ((IDEX_RegWrite & IDEX_Rd≠0 & IDEX_Rd==IFID_Rs) | (EXMem_MemRead & EXMem_Rd≠0 & EXMem_Rd==IFID_Rs)).
- br_go = branch_taken & IFID_Branch & ~br_dep. branch_taken is ignored whenever br_dep=1.
- FSM states are RUN and FREEZE. It also holds a 1-bit flush_pend.
- Output priority is freeze, then flush, then stall.
- RUN, mem_stall=1:
  - Outputs: freeze=1, PC_write=0, IFID_write=0, IDEX_bubble=0, IFID_flush=0.
  - Next state is FREEZE.
  - flush_pend is set to br_go.
- RUN, mem_stall=0, (br_go | flush_pend):
  - Outputs: IFID_flush=1, PC_write=1, IFID_write=1, IDEX_bubble=0.
  - flush_pend is cleared.
- RUN, mem_stall=0, otherwise, (load_use | br_dep): PC_write=0, IFID_write=0, IDEX_bubble=1.
- RUN, none of the above: PC_write=1, IFID_write=1, all other outputs 0.
- FREEZE:
  - freeze=1, PC_write=0, IFID_write=0 while mem_stall=1.
  - flush_pend |= br_go.
  - No bubble and no flush are issued.
- FREEZE, mem_stall=0: next state is RUN. In this same cycle, outputs follow the RUN rules, so a pending flush fires immediately.
- stall_cycles increments on every cycle with PC_write=0. bubble_count increments on every cycle with IDEX_bubble=1.
- Counters saturate at all-ones. cnt_clr has priority over increment.

## Timing
- All control outputs are combinational from current state, flush_pend and inputs, so they act on the same edge they are computed for. There is no added latency.
- Load-use costs exactly 1 bubble. A branch dependent on an EX ALU op costs 1 bubble. A branch dependent on an EX load costs 2 bubbles: one for the EX load, then one for the MEM load.
- A freeze lasts exactly as many cycles as mem_stall is high. A hazard present during a freeze is re-evaluated after exit; none is lost or double-counted.
- Asynchronous reset:
  - state=RUN, flush_pend=0, counters=0.
  - While rst=1, outputs are forced to PC_write=1, IFID_write=1, IDEX_bubble=0, IFID_flush=0, freeze=0.
- Reset mid-freeze drops the freeze and any pending flush immediately.
- Register 0 never creates a hazard.

## Test plan
- Load-use:
  - Stimulus: IDEX_MemRead=1, IDEX_Rd=3, IFID_Rs=3.
  - Required: one cycle of PC_write=0, IFID_write=0, IDEX_bubble=1.
  - Next cycle (IDEX_MemRead=0): PC_write=1. bubble_count=1, stall_cycles=1.
- Rt and R0 cases:
  - IDEX_Rd=5, IFID_Rt=5, IFID_UsesRt=0 -> no stall.
  - Same with UsesRt=1 -> stall.
  - IDEX_Rd=0 matching Rs=0 -> no stall.
- Branch behind a load:
  - Stimulus: IFID_Branch=1, Rs=7, IDEX load to R7, then the load moves to EXMem_Rd=7.
  - Required: 2 bubbles, branch_taken ignored both cycles.
  - Then, with branch_taken=1: IFID_flush=1 for 1 cycle.
- Freeze with pending flush:
  - Stimulus: mem_stall=1 for 4 cycles while br_go=1.
  - Required: freeze=1 for 4 cycles, IFID_flush=0 throughout, then IFID_flush=1 in the first cycle after mem_stall falls. stall_cycles=4.
- Async reset mid-freeze:
  - Stimulus: assert rst at cycle 2 of a freeze.
  - Required: outputs go to reset values without waiting for an edge, counters read 0, and no flush follows the release of rst.
- Saturation:
  - Stimulus: preload via a long stall with CNT_W=4, run 20 stall cycles.
  - Required: stall_cycles=15. Then cnt_clr with a concurrent stall gives 0.
